// File: rtl/pika_pkg.sv
// Shared types and constants for the instruction memory controller.
// Holds the controller state encoding and the default fill word.
package pika_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;
  localparam int          WCNT_W      = 3;

endpackage

// File: rtl/instr_mem_ctrl_array.sv
// Instruction storage: DEPTH x DATA_W, one sync write, one comb read.
// Ports: clk, we/waddr/wdata write port, raddr/rdata read port.
module instr_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction fetch memory with post-reset clear, load port and latency.
// Ports: clk, reset_n, req_*, rsp_*, ld_* load port, busy during clear.
module instr_mem_ctrl
  import pika_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 22,
  parameter int                DEPTH    = 256,
  parameter int                LATENCY  = 0,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              busy
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);
  localparam logic [WCNT_W-1:0] LAT_M1 =
    (LATENCY > 0) ? WCNT_W'(LATENCY - 1) : '0;
  localparam state_e ST_ACC = (LATENCY == 0) ? ST_RESP : ST_WAIT;

  state_e            st_q, st_d;
  logic [IW:0]       clr_q, clr_d;
  logic [WCNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              err_q, err_d;

  logic              accept, req_oob, ld_ok;
  logic              we;
  logic [IW-1:0]     waddr;
  logic [DATA_W-1:0] wdata, rdata;

  assign req_oob   = {1'b0, req_addr} >= DEPTH_A;
  assign ld_ok     = ld_en && ({1'b0, ld_addr} < DEPTH_A);
  assign req_ready = (st_q == ST_IDLE) ||
                     (st_q == ST_RESP && rsp_ready);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (st_q == ST_RESP);
  assign busy      = (st_q == ST_CLEAR);
  assign rsp_data  = dat_q;
  assign rsp_err   = err_q;

  // Clear owns the write port; loads are dropped meanwhile.
  always_comb begin
    we    = 1'b0;
    waddr = ld_addr[IW-1:0];
    wdata = ld_data;
    if (st_q == ST_CLEAR) begin
      we    = 1'b1;
      waddr = clr_q[IW-1:0];
      wdata = NOP_WORD;
    end else if (ld_ok) begin
      we = 1'b1;
    end
  end

  instr_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_arr (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (req_addr[IW-1:0]),
    .rdata (rdata)
  );

  // Read data is captured on the accept edge, so a same-edge
  // load is not visible and later loads cannot disturb it.
  always_comb begin
    st_d  = st_q;
    clr_d = clr_q;
    cnt_d = cnt_q;
    dat_d = dat_q;
    err_d = err_q;
    if (accept) begin
      dat_d = req_oob ? NOP_WORD : rdata;
      err_d = req_oob;
      cnt_d = LAT_M1;
    end
    unique case (st_q)
      ST_CLEAR: begin
        clr_d = clr_q + 1'b1;
        if (clr_d[IW]) st_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (accept) st_d = ST_ACC;
      end
      ST_WAIT: begin
        if (cnt_q == '0) st_d = ST_RESP;
        else cnt_d = cnt_q - 1'b1;
      end
      ST_RESP: begin
        if (rsp_ready) st_d = accept ? ST_ACC : ST_IDLE;
      end
      default: st_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q  <= ST_CLEAR;
      clr_q <= '0;
      cnt_q <= '0;
      dat_q <= NOP_WORD;
      err_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      clr_q <= clr_d;
      cnt_q <= cnt_d;
      dat_q <= dat_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Directed bench for instr_mem_ctrl at LATENCY 0 and LATENCY 3.
// Drives and samples on the falling clock edge.
module tb_instr_mem_ctrl;

  logic        clk;
  logic        rst_n, req_valid, req_ready, rsp_valid, rsp_ready;
  logic [21:0] req_addr, ld_addr;
  logic [31:0] rsp_data, ld_data;
  logic        rsp_err, ld_en, busy;

  logic        b_rst_n, b_req_valid, b_req_ready, b_rsp_valid;
  logic        b_rsp_ready, b_rsp_err, b_ld_en, b_busy;
  logic [21:0] b_req_addr, b_ld_addr;
  logic [31:0] b_rsp_data, b_ld_data;

  int total = 0;
  int bad   = 0;

  instr_mem_ctrl u0 (
    .clk       (clk),
    .reset_n   (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .busy      (busy)
  );

  instr_mem_ctrl #(
    .DEPTH    (16),
    .LATENCY  (3),
    .NOP_WORD (32'h0000_0013)
  ) u3 (
    .clk       (clk),
    .reset_n   (b_rst_n),
    .req_valid (b_req_valid),
    .req_ready (b_req_ready),
    .req_addr  (b_req_addr),
    .rsp_valid (b_rsp_valid),
    .rsp_ready (b_rsp_ready),
    .rsp_data  (b_rsp_data),
    .rsp_err   (b_rsp_err),
    .ld_en     (b_ld_en),
    .ld_addr   (b_ld_addr),
    .ld_data   (b_ld_data),
    .busy      (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic ld0(input logic [21:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic rd0(input string tag, input logic [21:0] a,
                     input logic [31:0] d, input logic e);
    req_valid = 1'b1; req_addr = a; rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_v"}, rsp_valid, 1);
    chk(tag, rsp_data, d);
    chk({tag, "_e"}, rsp_err, e);
    @(negedge clk);
    chk({tag, "_done"}, rsp_valid, 0);
  endtask

  task automatic rd3(input string tag, input logic [21:0] a,
                     input logic [31:0] d, input logic e,
                     input bit poke);
    int n;
    b_req_valid = 1'b1; b_req_addr = a; b_rsp_ready = 1'b1;
    @(negedge clk);
    b_req_valid = 1'b0;
    n = 1;
    if (poke) begin
      b_ld_en = 1'b1; b_ld_addr = a; b_ld_data = 32'h0BAD_F00D;
    end
    while (!b_rsp_valid && n < 20) begin
      @(negedge clk);
      b_ld_en = 1'b0;
      n++;
    end
    b_ld_en = 1'b0;
    chk({tag, "_lat"}, 32'(n), 32'd4);
    chk(tag, b_rsp_data, d);
    chk({tag, "_e"}, b_rsp_err, e);
    @(negedge clk);
    chk({tag, "_done"}, b_rsp_valid, 0);
  endtask

  initial begin
    int n;
    bit seen;
    rst_n = 0; req_valid = 0; req_addr = '0; rsp_ready = 0;
    ld_en = 0; ld_addr = '0; ld_data = '0;
    b_rst_n = 0; b_req_valid = 0; b_req_addr = '0; b_rsp_ready = 0;
    b_ld_en = 0; b_ld_addr = '0; b_ld_data = '0;
    repeat (3) @(negedge clk);

    chk("rst_busy", busy, 1);
    chk("rst_rdy", req_ready, 0);
    chk("rst_rv", rsp_valid, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_data", rsp_data, 32'h0);
    chk("rst3_data", b_rsp_data, 32'h13);
    chk("rst3_busy", b_busy, 1);

    rst_n = 1; b_rst_n = 1;
    n = 0;
    while (busy && n < 300) begin
      chk("clr_rdy", req_ready, 0);
      n++;
      @(negedge clk);
    end
    chk("clr_cycles", 32'(n), 32'd256);
    chk("idle_rdy", req_ready, 1);

    rd0("rd5", 22'd5, 32'h0, 1'b0);
    ld0(22'd3, 32'hDEAD_BEEF);
    rd0("rd3", 22'd3, 32'hDEAD_BEEF, 1'b0);
    ld0(22'd255, 32'hA5A5_0FF0);
    rd0("rd255", 22'd255, 32'hA5A5_0FF0, 1'b0);
    rd0("rd256", 22'd256, 32'h0, 1'b1);
    rd0("rd259", 22'd259, 32'h0, 1'b1);
    ld0(22'd300, 32'h5555_5555);
    rd0("rd44", 22'd44, 32'h0, 1'b0);

    req_valid = 1; req_addr = 22'd3; rsp_ready = 0;
    @(negedge clk);
    req_addr = 22'd255;
    for (int i = 0; i < 5; i++) begin
      chk("bp_v", rsp_valid, 1);
      chk("bp_d", rsp_data, 32'hDEAD_BEEF);
      chk("bp_rdy", req_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1;
    #1 chk("bp_rdy1", req_ready, 1);
    @(negedge clk);
    chk("b2b1_v", rsp_valid, 1);
    chk("b2b1_d", rsp_data, 32'hA5A5_0FF0);
    req_addr = 22'd5;
    @(negedge clk);
    chk("b2b2_v", rsp_valid, 1);
    chk("b2b2_d", rsp_data, 32'h0);
    req_valid = 0;
    @(negedge clk);
    chk("b2b_done", rsp_valid, 0);

    ld_en = 1; ld_addr = 22'd7; ld_data = 32'h1234_5678;
    req_valid = 1; req_addr = 22'd7; rsp_ready = 1;
    @(negedge clk);
    ld_en = 0; req_valid = 0;
    chk("rbw_v", rsp_valid, 1);
    chk("rbw_d", rsp_data, 32'h0);
    @(negedge clk);
    rd0("rd7", 22'd7, 32'h1234_5678, 1'b0);

    chk("l3_rdy", b_req_ready, 1);
    b_ld_en = 1; b_ld_addr = 22'd3; b_ld_data = 32'hDEAD_BEEF;
    @(negedge clk);
    b_ld_en = 0;
    rd3("l3_rd3", 22'd3, 32'hDEAD_BEEF, 1'b0, 1'b1);
    rd3("l3_poke", 22'd3, 32'h0BAD_F00D, 1'b0, 1'b0);
    rd3("l3_oob", 22'd16, 32'h13, 1'b1, 1'b0);

    b_req_valid = 1; b_req_addr = 22'd3; b_rsp_ready = 1;
    @(negedge clk);
    b_req_valid = 0;
    @(negedge clk);
    b_rst_n = 0;
    #1;
    chk("mid_rv", b_rsp_valid, 0);
    chk("mid_busy", b_busy, 1);
    chk("mid_rdy", b_req_ready, 0);
    chk("mid_d", b_rsp_data, 32'h13);
    @(negedge clk);
    b_rst_n = 1;
    n = 0; seen = 0;
    while (b_busy && n < 100) begin
      seen |= b_rsp_valid;
      b_ld_en = (n == 10); b_ld_addr = 22'd3;
      b_ld_data = 32'hFFFF_0000;
      n++;
      @(negedge clk);
    end
    b_ld_en = 0;
    chk("mid_clr", 32'(n), 32'd16);
    chk("mid_norsp", 32'(seen), 32'd0);
    rd3("mid_rd3", 22'd3, 32'h13, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_mem_ctrl.md
INSTR_MEM_CTRL -- requirements
Module: instr_mem_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, instruction word width.
REQ-002 The block SHALL have parameter ADDR_W, default 22, word-address width.
REQ-003 The block SHALL have parameter DEPTH, default 256, number of words; power of two, at most 2^ADDR_W.
REQ-004 The block SHALL have parameter LATENCY, default 0, extra wait cycles per read, range 0..7.
REQ-005 The block SHALL have parameter NOP_WORD, default 32'h0000_0000, clear and error fill value.
REQ-006 The block SHALL have ports clk in 1, the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port reset_n in 1: reset is asynchronous and active-low.
REQ-008 The block SHALL have ports req_valid in 1, req_ready out 1 and req_addr in ADDR_W, the fetch request handshake.
REQ-009 The block SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_data out DATA_W and rsp_err out 1, the fetch response handshake.
REQ-010 The block SHALL have ports ld_en in 1, ld_addr in ADDR_W and ld_data in DATA_W, the program-load write port.
REQ-011 The block SHALL have port busy out 1, high while the post-reset clear is running.

Function
REQ-012 States SHALL be CLEAR, IDLE, WAIT and RESP.
REQ-013 CLEAR: one word per cycle, indices 0..DEPTH-1, SHALL be written with NOP_WORD; DEPTH cycles; busy=1, req_ready=0; then IDLE.
REQ-014 req_ready SHALL be (state==IDLE) or (state==RESP and rsp_ready).
REQ-015 A request SHALL be accepted on the clk edge with req_valid and req_ready both high; req_addr and the read data are sampled at that edge.
REQ-016 With LATENCY=0, rsp_valid SHALL assert on the cycle after acceptance.
REQ-017 With LATENCY=N>0, WAIT SHALL last N cycles; rsp_valid asserts N+1 cycles after acceptance.
REQ-018 In RESP, rsp_data and rsp_err SHALL stay stable until the rsp_valid and rsp_ready handshake.
REQ-019 On the response handshake with no new acceptance, the block SHALL go to IDLE and deassert rsp_valid.
REQ-020 On the response handshake with a simultaneous acceptance, the block SHALL go to RESP (LATENCY=0) or WAIT, giving one word per cycle at LATENCY=0.
REQ-021 Index SHALL be req_addr[log2(DEPTH)-1:0]; req_addr >= DEPTH SHALL give rsp_err=1 and rsp_data=NOP_WORD.
REQ-022 When ld_en=1 outside CLEAR, ld_data SHALL be written at ld_addr on the edge; it is ignored during CLEAR or when ld_addr >= DEPTH.
REQ-023 A load and an accepted read to the same index on the same edge SHALL return the old word (read-before-write).
REQ-024 A load to the index of an in-flight (WAIT/RESP) request SHALL NOT change that response.
REQ-025 With LATENCY=0, a back-to-back read issued the cycle after a load SHALL return the loaded word.

Reset
REQ-026 While reset_n=0: state SHALL be CLEAR with the clear index 0; req_ready=0, rsp_valid=0, rsp_data=NOP_WORD, rsp_err=0, busy=1.
REQ-027 Reset asserted mid-operation SHALL immediately drop any in-flight request and response with no handshake completion; clear SHALL restart from index 0 after release.
REQ-028 Memory contents SHALL be defined only by the clear sequence, not by reset itself.

Structure
REQ-029 The shared package pika_pkg SHALL hold the state encoding constants and the default NOP_WORD.
REQ-030 Storage SHALL be the sub-module instr_mem_array: DEPTH x DATA_W, one synchronous write port, one read port; its array is not reset.
REQ-031 A wait counter SHALL be 3 bits; the clear index SHALL be log2(DEPTH)+1 bits so that termination is detected.

Verification
REQ-032 Reset then release with DEPTH=256 -> busy=1 for exactly 256 cycles, then req_ready=1; a read of addr 5 -> 32'h0000_0000, rsp_err=0.
REQ-033 Load addr 3 = 32'hDEAD_BEEF, then read addr 3 with LATENCY=0 -> rsp_valid the next cycle, data 32'hDEAD_BEEF; with LATENCY=3 -> rsp_valid 4 cycles after acceptance.
REQ-034 Reads of addr 255 and addr 256 -> loaded data with rsp_err=0, then NOP_WORD with rsp_err=1.
REQ-035 rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_data stable, req_ready=0; then rsp_ready=1 with req_valid=1 -> back-to-back accept, one response per cycle at LATENCY=0.
REQ-036 Load addr 7 = 32'h1234_5678 on the same edge as a read acceptance of addr 7 -> response is the old word; a following read returns 32'h1234_5678.
REQ-037 reset_n pulsed low during WAIT -> rsp_valid=0 at once, no response emitted, clear restarts from 0, and a load issued during CLEAR is dropped.
